// File: rtl/bert_fixed_pkg.sv
// Shared fixed-point helpers for the BERT encoder datapath: accumulator sizing
// and the dot-product accumulator state encoding.
package bert_fixed_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Full-precision accumulator width: product bits plus lane and beat growth.
  function automatic int unsigned acc_width(input int unsigned dw,
                                            input int unsigned ww,
                                            input int unsigned p,
                                            input int unsigned d);
    return dw + ww + $clog2(p) + $clog2(d);
  endfunction

endpackage

// File: rtl/fixed_dot_chunk.sv
// Combinational signed dot product of one PARALLELISM-wide chunk:
// per-lane multiply followed by a balanced adder tree.
module fixed_dot_chunk #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WEIGHT_W    = 16,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned SUM_W       = DATA_W + WEIGHT_W + $clog2(PARALLELISM)
) (
  input  logic        [PARALLELISM-1:0][DATA_W-1:0]   data_in,
  input  logic        [PARALLELISM-1:0][WEIGHT_W-1:0] weight,
  output logic signed [SUM_W-1:0]                     chunk_sum
);

  localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
  localparam int unsigned LVL    = $clog2(PARALLELISM);
  localparam int unsigned LEAVES = 1 << LVL;

  // Heap-ordered tree: leaves at LEAVES-1.., root at index 0.
  logic signed [SUM_W-1:0] w_node [2*LEAVES-1];

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < PARALLELISM) begin : g_lane
        logic signed [PROD_W-1:0] w_prod;
        assign w_prod = PROD_W'($signed(data_in[gi])) * PROD_W'($signed(weight[gi]));
        assign w_node[LEAVES-1+gi] = SUM_W'(w_prod);
      end else begin : g_pad
        assign w_node[LEAVES-1+gi] = '0;
      end
    end

    for (gi = 0; gi < LEAVES - 1; gi++) begin : g_add
      assign w_node[gi] = w_node[2*gi+1] + w_node[2*gi+2];
    end
  endgenerate

  assign chunk_sum = w_node[0];

endmodule

// File: rtl/key_proj_dot_accumulator.sv
// Joins activation and projection-weight chunk streams and accumulates IN_DEPTH
// chunk products into one full-precision signed dot product on a valid/ready output.
module key_proj_dot_accumulator
  import bert_fixed_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DATA_FRAC   = 3,
  parameter int unsigned WEIGHT_W    = 16,
  parameter int unsigned WEIGHT_FRAC = 3,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned IN_DEPTH    = 8,
  parameter int unsigned ACC_W       = acc_width(DATA_W, WEIGHT_W, PARALLELISM, IN_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PARALLELISM-1:0][DATA_W-1:0]    data_in,
  input  logic                                  data_in_valid,
  output logic                                  data_in_ready,
  input  logic [PARALLELISM-1:0][WEIGHT_W-1:0]  weight,
  input  logic                                  weight_valid,
  output logic                                  weight_ready,
  output logic signed [ACC_W-1:0]               data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready
);

  localparam int unsigned SUM_W = DATA_W + WEIGHT_W + $clog2(PARALLELISM);
  localparam int unsigned CNT_W = $clog2(IN_DEPTH) + 1;

  // Result binary point sits at DATA_FRAC+WEIGHT_FRAC; it must fit the result.
  generate
    if (IN_DEPTH < 1 || DATA_FRAC + WEIGHT_FRAC >= ACC_W) begin : g_param_check
      $error("key_proj_dot_accumulator: invalid IN_DEPTH or fractional widths");
    end
  endgenerate

  acc_state_t              r_state;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_data_out;
  logic                    r_data_out_valid;

  logic                    w_can_accept;
  logic                    w_fire;
  logic                    w_last;
  logic signed [SUM_W-1:0] w_chunk_sum;
  logic signed [ACC_W-1:0] w_sum;

  fixed_dot_chunk #(
    .DATA_W      (DATA_W),
    .WEIGHT_W    (WEIGHT_W),
    .PARALLELISM (PARALLELISM),
    .SUM_W       (SUM_W)
  ) u_chunk (
    .data_in   (data_in),
    .weight    (weight),
    .chunk_sum (w_chunk_sum)
  );

  // Join: each ready depends only on the other side's valid, never its own.
  assign w_can_accept  = (r_state == ACCUM) | data_out_ready;
  assign data_in_ready = weight_valid & w_can_accept;
  assign weight_ready  = data_in_valid & w_can_accept;
  assign w_fire        = data_in_valid & weight_valid & w_can_accept;

  assign w_last = (r_beat_cnt == CNT_W'(IN_DEPTH - 1));
  assign w_sum  = r_acc + ACC_W'(w_chunk_sum);

  // In HOLD the accumulator is already zero, so a draining-cycle fire is beat 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ACCUM;
      r_beat_cnt       <= '0;
      r_acc            <= '0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_fire) begin
            if (w_last) begin
              r_data_out       <= w_sum;
              r_data_out_valid <= 1'b1;
              r_acc            <= '0;
              r_beat_cnt       <= '0;
              r_state          <= HOLD;
            end else begin
              r_acc      <= w_sum;
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (data_out_ready) begin
            if (w_fire && w_last) begin
              r_data_out <= w_sum;
            end else if (w_fire) begin
              r_acc            <= w_sum;
              r_beat_cnt       <= r_beat_cnt + CNT_W'(1);
              r_data_out_valid <= 1'b0;
              r_state          <= ACCUM;
            end else begin
              r_data_out_valid <= 1'b0;
              r_state          <= ACCUM;
            end
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_key_proj_dot_accumulator.sv
// Directed bench for key_proj_dot_accumulator (PARALLELISM=4, IN_DEPTH=3).
module tb_key_proj_dot_accumulator;

  localparam int unsigned DW    = 16;
  localparam int unsigned WW    = 16;
  localparam int unsigned P     = 4;
  localparam int unsigned D     = 3;
  localparam int unsigned ACC_W = DW + WW + 2 + 2;

  logic                       clk;
  logic                       rst;
  logic [P-1:0][DW-1:0]       data_in;
  logic                       data_in_valid;
  logic                       data_in_ready;
  logic [P-1:0][WW-1:0]       weight;
  logic                       weight_valid;
  logic                       weight_ready;
  logic signed [ACC_W-1:0]    data_out;
  logic                       data_out_valid;
  logic                       data_out_ready;

  int n_pass  = 0;
  int n_total = 0;

  key_proj_dot_accumulator #(
    .DATA_W      (DW),
    .DATA_FRAC   (3),
    .WEIGHT_W    (WW),
    .WEIGHT_FRAC (3),
    .PARALLELISM (P),
    .IN_DEPTH    (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .weight         (weight),
    .weight_valid   (weight_valid),
    .weight_ready   (weight_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d0, input int d1, input int d2, input int d3,
                       input int w0, input int w1, input int w2, input int w3);
    data_in[0] = DW'(d0); data_in[1] = DW'(d1);
    data_in[2] = DW'(d2); data_in[3] = DW'(d3);
    weight[0]  = WW'(w0); weight[1]  = WW'(w1);
    weight[2]  = WW'(w2); weight[3]  = WW'(w3);
  endtask

  initial begin
    rst            = 1'b1;
    data_in_valid  = 1'b0;
    weight_valid   = 1'b0;
    data_out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset_valid", 64'(data_out_valid), 64'sd0);
    chk("reset_out", data_out, 64'sd0);
    chk("reset_din_ready", 64'(data_in_ready), 64'sd0);
    rst = 1'b0;

    // Basic: [1,2,3,4].[1,1,1,1] x3 -> 30
    drive(1, 2, 3, 4, 1, 1, 1, 1);
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    step();
    chk("basic_valid_b1", 64'(data_out_valid), 64'sd0);
    step();
    chk("basic_valid_b2", 64'(data_out_valid), 64'sd0);
    step();
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    chk("basic_valid", 64'(data_out_valid), 64'sd1);
    chk("basic_out", data_out, 64'sd30);
    step();
    chk("basic_valid_drop", 64'(data_out_valid), 64'sd0);

    // Signed extremes: 12 lanes*beats of 2^30
    drive(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    step();
    step();
    step();
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    chk("extreme_valid", 64'(data_out_valid), 64'sd1);
    chk("extreme_out", data_out, 64'sd12884901888);
    step();

    // Backpressure: hold 5 cycles, release accepts a beat in the same cycle
    data_out_ready = 1'b0;
    drive(1, 2, 3, 4, 1, 1, 1, 1);
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    step();
    step();
    step();
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(data_out_valid), 64'sd1);
      chk("bp_out", data_out, 64'sd30);
      chk("bp_din_ready", 64'(data_in_ready), 64'sd0);
      chk("bp_w_ready", 64'(weight_ready), 64'sd0);
      step();
    end
    data_out_ready = 1'b1;
    #1;
    chk("bp_release_din_ready", 64'(data_in_ready), 64'sd1);
    chk("bp_release_w_ready", 64'(weight_ready), 64'sd1);
    step();
    chk("bp_drained", 64'(data_out_valid), 64'sd0);
    step();
    step();
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    chk("bp_next_valid", 64'(data_out_valid), 64'sd1);
    chk("bp_next_out", data_out, 64'sd12);
    step();

    // Join gaps: weight_valid 1,0,1,0,1 -> 3 fires, 3*8=24
    drive(1, 1, 1, 1, 2, 2, 2, 2);
    data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      weight_valid = (i % 2 == 0);
      #1;
      chk("gap_din_ready", 64'(data_in_ready), 64'(weight_valid));
      chk("gap_w_ready", 64'(weight_ready), 64'sd1);
      step();
      if (i < 4) chk("gap_valid_early", 64'(data_out_valid), 64'sd0);
    end
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    chk("gap_valid", 64'(data_out_valid), 64'sd1);
    chk("gap_out", data_out, 64'sd24);
    step();

    // Streaming: beat k = [k,0,0,0].[1,0,0,0], k=0..8 -> 3, 12, 21
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(k, 0, 0, 0, 1, 0, 0, 0);
      step();
      if (k % 3 == 2) begin
        chk("stream_valid", 64'(data_out_valid), 64'sd1);
        chk("stream_out", data_out, 64'(3 * k - 3));
      end else begin
        chk("stream_idle", 64'(data_out_valid), 64'sd0);
      end
    end
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    step();
    chk("stream_end", 64'(data_out_valid), 64'sd0);

    // Reset mid-accumulation discards the two 100-beats
    drive(100, 0, 0, 0, 1, 0, 0, 0);
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    step();
    step();
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_mid_valid", 64'(data_out_valid), 64'sd0);
    chk("rst_mid_out", data_out, 64'sd0);
    rst = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    step();
    step();
    chk("rst_post_valid_b2", 64'(data_out_valid), 64'sd0);
    step();
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    chk("rst_post_valid", 64'(data_out_valid), 64'sd1);
    chk("rst_post_out", data_out, 64'sd12);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
